mem_refill_arbiter: RTL

Shares the single 128-bit main-memory line port between the instruction-cache refill path and the data-cache refill/writeback path. It arbitrates between the two requesters with round-robin priority and sequences the fixed LATENCY-cycle memory access; this replaces the per-cache wait counter. It returns the fetched line with a one-cycle ack pulse. It sits between fetch_instruction_memory / the data cache and the main memory model.

---
 rtl/mem_refill_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter that shares one main-memory line port between the I-cache
// refill path and the D-cache refill/writeback path, sequencing a fixed-latency access.
module mem_refill_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_line,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_line,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_d;   // last grant went to D
    logic          r_gnt_d;    // current transaction belongs to D
    logic          w_pick_d;

    // With both requests pending, the side that did not win last time goes next.
    assign w_pick_d = d_req && (!i_req || !r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_d  <= 1'b1;
            r_gnt_d   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_line    <= '0;
            d_line    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        r_state   <= S_ACCESS;
                        r_cnt     <= '0;
                        r_gnt_d   <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        mem_en    <= 1'b1;
                        mem_we    <= w_pick_d & d_we;
                        mem_addr  <= w_pick_d ? d_addr : i_addr;
                        mem_wdata <= w_pick_d ? d_wdata : '0;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        r_state <= S_RESP;
                        if (!mem_we) begin
                            if (r_gnt_d) d_line <= mem_rdata;
                            else         i_line <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_ack = (r_state == S_RESP) && !r_gnt_d;
    assign d_ack = (r_state == S_RESP) &&  r_gnt_d;
    assign busy  = (r_state != S_IDLE);

endmodule
